// File: rtl/inv_sqrt_seq.sv
// Inverse square root sequencer: bit-hack seed plus ITERS Newton steps, with every
// multiply/subtract issued to a shared FPU over a req/ack port.
module inv_sqrt_seq #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10,
  parameter logic [EXP_W+MAN_W:0] MAGIC = 16'h59BB,
  parameter logic [EXP_W+MAN_W:0] ONE_P5 = 16'h3E00,
  parameter int unsigned ITERS = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   x_in,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [1:0]             ofuf,
  output logic                   fpu_req,
  output logic [1:0]             fpu_op,
  output logic [EXP_W+MAN_W:0]   fpu_a,
  output logic [EXP_W+MAN_W:0]   fpu_b,
  input  logic                   fpu_ack,
  input  logic [EXP_W+MAN_W:0]   fpu_result,
  input  logic [1:0]             fpu_ofuf
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  localparam logic [1:0] OP_SUB   = 2'd1;
  localparam logic [1:0] OP_MUL   = 2'd2;
  localparam logic [1:0] OF_OK    = 2'b00;
  localparam logic [1:0] OF_UNDER = 2'b01;
  localparam logic [1:0] OF_OVER  = 2'b10;
  localparam logic [1:0] OF_INV   = 2'b11;

  localparam logic [W-1:0] POS_INF = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [W-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-1:0] ONE     = {2'b00, {(EXP_W-1){1'b1}}, {MAN_W{1'b0}}};
  localparam logic [EXP_W-1:0] EXP_ONE = 1;

  typedef enum logic [2:0] {
    IDLE, CHECK, MUL_YY, MUL_XH, SUB, MUL_Y, GAP, DONE
  } state_t;

  state_t state, stateN, after, afterN;
  logic [W-1:0] xReg, xRegN, y, yN, t, tN, xhalf, xhalfN;
  logic [2:0]   iter, iterN;
  logic         busyN, doneN, reqN;
  logic [W-1:0] resultN, aN, bN;
  logic [1:0]   ofufN, opN;

  logic             sgn;
  logic [EXP_W-1:0] expF;
  logic [MAN_W-1:0] manF;
  logic [W:0]       seedWide;

  assign sgn      = xReg[W-1];
  assign expF     = xReg[W-2:MAN_W];
  assign manF     = xReg[MAN_W-1:0];
  // Extra MSB catches a borrow when x>>1 exceeds the magic constant.
  assign seedWide = {1'b0, MAGIC} - {2'b00, xReg[W-1:1]};

  always_comb begin
    stateN  = state;
    afterN  = after;
    xRegN   = xReg;
    yN      = y;
    tN      = t;
    xhalfN  = xhalf;
    iterN   = iter;
    busyN   = busy;
    doneN   = 1'b0;
    resultN = result;
    ofufN   = ofuf;
    reqN    = fpu_req;
    opN     = fpu_op;
    aN      = fpu_a;
    bN      = fpu_b;
    unique case (state)
      IDLE: begin
        if (start) begin
          xRegN  = x_in;
          ofufN  = OF_OK;
          busyN  = 1'b1;
          stateN = CHECK;
        end
      end
      CHECK: begin
        stateN = DONE;
        doneN  = 1'b1;
        if (xReg[W-2:0] == '0) begin
          resultN = POS_INF;
          ofufN   = OF_OVER;
        end else if (sgn) begin
          resultN = QNAN;
          ofufN   = OF_INV;
        end else if (expF == '1 && manF != '0) begin
          resultN = QNAN;
          ofufN   = OF_INV;
        end else if (expF == '1) begin
          resultN = '0;
          ofufN   = OF_OK;
        end else if (xReg == ONE) begin
          resultN = xReg;
          ofufN   = OF_OK;
        end else if (expF == '0) begin
          resultN = '0;
          ofufN   = OF_UNDER;
        end else if (seedWide[W]) begin
          resultN = '0;
          ofufN   = OF_OVER;
        end else begin
          stateN = MUL_YY;
          doneN  = 1'b0;
          yN     = seedWide[W-1:0];
          xhalfN = {sgn, expF - EXP_ONE, manF};
          iterN  = '0;
          reqN   = 1'b1;
          opN    = OP_MUL;
          aN     = seedWide[W-1:0];
          bN     = seedWide[W-1:0];
        end
      end
      MUL_YY, MUL_XH, SUB, MUL_Y: begin
        if (fpu_req && fpu_ack) begin
          reqN   = 1'b0;
          stateN = GAP;
          tN     = fpu_result;
          case (state)
            MUL_YY: afterN = MUL_XH;
            MUL_XH: afterN = SUB;
            SUB:    afterN = MUL_Y;
            MUL_Y: begin
              yN    = fpu_result;
              iterN = iter + 3'd1;
              if ((32'(iter) + 32'd1) < ITERS) begin
                afterN = MUL_YY;
              end else begin
                afterN  = DONE;
                resultN = fpu_result;
              end
            end
            default: afterN = DONE;
          endcase
          if (fpu_ofuf != OF_OK) begin
            ofufN   = fpu_ofuf;
            resultN = fpu_result;
            afterN  = DONE;
          end
        end
      end
      GAP: begin
        stateN = after;
        if (after == DONE) begin
          doneN = 1'b1;
        end else begin
          reqN = 1'b1;
          case (after)
            MUL_YY:  begin opN = OP_MUL; aN = y;      bN = y; end
            MUL_XH:  begin opN = OP_MUL; aN = xhalf;  bN = t; end
            SUB:     begin opN = OP_SUB; aN = ONE_P5; bN = t; end
            default: begin opN = OP_MUL; aN = y;      bN = t; end
          endcase
        end
      end
      DONE: begin
        busyN  = 1'b0;
        stateN = IDLE;
      end
      default: stateN = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      after   <= IDLE;
      xReg    <= '0;
      y       <= '0;
      t       <= '0;
      xhalf   <= '0;
      iter    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      ofuf    <= '0;
      fpu_req <= 1'b0;
      fpu_op  <= '0;
      fpu_a   <= '0;
      fpu_b   <= '0;
    end else begin
      state   <= stateN;
      after   <= afterN;
      xReg    <= xRegN;
      y       <= yN;
      t       <= tN;
      xhalf   <= xhalfN;
      iter    <= iterN;
      busy    <= busyN;
      done    <= doneN;
      result  <= resultN;
      ofuf    <= ofufN;
      fpu_req <= reqN;
      fpu_op  <= opN;
      fpu_a   <= aN;
      fpu_b   <= bN;
    end
  end
endmodule

// File: tb/tb_inv_sqrt_seq.sv
// Scoreboard bench for inv_sqrt_seq: two instances (ITERS=1, ITERS=3) served by a
// behavioural binary16 FPU with fixed or randomised latency.
module tb_inv_sqrt_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic start1, start3;
  logic [15:0] x1, x3;
  logic busy1, busy3, done1, done3, req1, req3;
  logic [15:0] res1, res3, a1, a3, b1, b3;
  logic [1:0] of1, of3, op1, op3;
  logic ack1, ack3;
  logic [15:0] fres1, fres3;
  logic [1:0] fof1, fof3;

  inv_sqrt_seq #(.EXP_W(5), .MAN_W(10), .MAGIC(16'h59BB), .ONE_P5(16'h3E00), .ITERS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .x_in(x1), .busy(busy1), .done(done1),
    .result(res1), .ofuf(of1), .fpu_req(req1), .fpu_op(op1), .fpu_a(a1), .fpu_b(b1),
    .fpu_ack(ack1), .fpu_result(fres1), .fpu_ofuf(fof1));

  inv_sqrt_seq #(.EXP_W(5), .MAN_W(10), .MAGIC(16'h59BB), .ONE_P5(16'h3E00), .ITERS(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .x_in(x3), .busy(busy3), .done(done3),
    .result(res3), .ofuf(of3), .fpu_req(req3), .fpu_op(op3), .fpu_a(a3), .fpu_b(b3),
    .fpu_ack(ack3), .fpu_result(fres3), .fpu_ofuf(fof3));

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [1:0]  ofuf;
    int          lat;
    int          reqs;
    int          startCyc;
    int          reqBase;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int reqRise[2];
  logic prevReq[2];
  logic idleNext[2];
  logic pend[2];
  int cnt[2];
  logic [1:0] opL[2];
  logic [15:0] aL[2], bL[2];
  int ackSeen = 0;
  logic errArm = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d..%0d (0x%0h..0x%0h)", nm, act, act, lo, hi, lo, hi);
    end
  endtask

  function automatic real h2r(input logic [15:0] h);
    real m;
    int e;
    e = int'(h[14:10]);
    if (e == 0) begin
      m = real'(int'(h[9:0])) / 16777216.0;
    end else begin
      m = (1024.0 + real'(int'(h[9:0]))) / 1024.0;
      for (int i = 0; i < e - 15; i++) m = m * 2.0;
      for (int i = 0; i < 15 - e; i++) m = m / 2.0;
    end
    return h[15] ? -m : m;
  endfunction

  // Round-to-nearest-even binary16 encoder; subnormal results flush to zero.
  function automatic logic [15:0] r2h(input real v);
    logic s;
    int e, ip;
    real m, frac, rem;
    s = (v < 0.0);
    m = s ? -v : v;
    if (m == 0.0) return {s, 15'd0};
    e = 0;
    while (m >= 2.0 && e < 64) begin m = m / 2.0; e++; end
    while (m < 1.0 && e > -64) begin m = m * 2.0; e--; end
    if (e < -14) return {s, 15'd0};
    if (e > 15) return {s, 5'h1F, 10'd0};
    frac = (m - 1.0) * 1024.0;
    ip = $rtoi(frac);
    rem = frac - real'(ip);
    if (rem > 0.5 || (rem == 0.5 && (ip % 2) == 1)) ip++;
    if (ip == 1024) begin ip = 0; e++; end
    if (e > 15) return {s, 5'h1F, 10'd0};
    return {s, 5'(e + 15), 10'(ip)};
  endfunction

  function automatic logic [15:0] fpuCalc(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    real ra, rb;
    ra = h2r(a);
    rb = h2r(b);
    case (op)
      2'd0: return r2h(ra + rb);
      2'd1: return r2h(ra - rb);
      2'd2: return r2h(ra * rb);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic fpuTick(input int d, input logic req, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, output logic ack, output logic [15:0] res, output logic [1:0] of);
    ack = 1'b0;
    res = '0;
    of = 2'b00;
    if (pend[d]) begin
      cnt[d]--;
      if (cnt[d] == 0) begin
        pend[d] = 1'b0;
        ack = 1'b1;
        res = fpuCalc(opL[d], aL[d], bL[d]);
        if (d == 0) begin
          ackSeen++;
          if (errArm && ackSeen == 2) begin
            res = '0;
            of = 2'b01;
            errArm = 1'b0;
          end
        end
      end
    end else if (req) begin
      pend[d] = 1'b1;
      opL[d] = op;
      aL[d] = a;
      bL[d] = b;
      cnt[d] = (d == 0) ? 1 : int'($urandom_range(6, 1));
    end
  endtask

  initial begin
    pend[0] = 1'b0; pend[1] = 1'b0;
    cnt[0] = 0; cnt[1] = 0;
    ack1 = 1'b0; ack3 = 1'b0;
    fres1 = '0; fres3 = '0;
    fof1 = '0; fof3 = '0;
    forever begin
      @(posedge clk);
      #1;
      fpuTick(0, req1, op1, a1, b1, ack1, fres1, fof1);
      fpuTick(1, req3, op3, a3, b3, ack3, fres3, fof3);
    end
  end

  task automatic mon(input int d, input logic dn, input logic bsy, input logic [15:0] res,
                     input logic [1:0] of, input logic req);
    exp_t e;
    if (req && !prevReq[d]) reqRise[d]++;
    prevReq[d] = req;
    if (idleNext[d]) begin
      idleNext[d] = 1'b0;
      chk($sformatf("dut%0d busy after done", d), int'(bsy), 0, 0);
    end
    if (dn) begin
      idleNext[d] = 1'b1;
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL dut%0d unexpected done: got done=1 result=0x%0h, want no done", d, res);
      end else begin
        if (d == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk({e.name, " result"}, int'(res), int'(e.lo), int'(e.hi));
        chk({e.name, " ofuf"}, int'(of), int'(e.ofuf), int'(e.ofuf));
        if (e.lat >= 0) chk({e.name, " latency"}, cyc - e.startCyc, e.lat, e.lat);
        chk({e.name, " fpu reqs"}, reqRise[d] - e.reqBase, e.reqs, e.reqs);
        chk({e.name, " busy at done"}, int'(bsy), 1, 1);
      end
    end
  endtask

  initial begin
    reqRise[0] = 0; reqRise[1] = 0;
    prevReq[0] = 1'b0; prevReq[1] = 1'b0;
    idleNext[0] = 1'b0; idleNext[1] = 1'b0;
    forever begin
      @(negedge clk);
      mon(0, done1, busy1, res1, of1, req1);
      mon(1, done3, busy3, res3, of3, req3);
    end
  end

  task automatic setStart(input int d, input logic s, input logic [15:0] x);
    if (d == 0) begin start1 = s; x1 = x; end
    else begin start3 = s; x3 = x; end
  endtask

  task automatic waitDrain(input int d);
    int n = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL dut%0d done timeout: got no done in 400 cycles, want done", d);
      if (d == 0) q0.delete();
      else q1.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic issue(input int d, input logic [15:0] x, input logic [15:0] lo, input logic [15:0] hi,
                       input logic [1:0] of, input int lat, input int reqs, input int hold,
                       input string nm, input bit track);
    exp_t e;
    @(negedge clk);
    e.lo = lo; e.hi = hi; e.ofuf = of; e.lat = lat; e.reqs = reqs;
    e.startCyc = cyc; e.reqBase = reqRise[d]; e.name = nm;
    if (track) begin
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    setStart(d, 1'b1, x);
    repeat (hold) @(negedge clk);
    setStart(d, 1'b0, x);
    if (track) waitDrain(d);
  endtask

  task automatic chkIdleOuts(input string tag);
    chk({tag, " dut1 busy"}, int'(busy1), 0, 0);
    chk({tag, " dut1 done"}, int'(done1), 0, 0);
    chk({tag, " dut1 result"}, int'(res1), 0, 0);
    chk({tag, " dut1 ofuf"}, int'(of1), 0, 0);
    chk({tag, " dut1 fpu_req"}, int'(req1), 0, 0);
    chk({tag, " dut3 busy"}, int'(busy3), 0, 0);
    chk({tag, " dut3 done"}, int'(done3), 0, 0);
    chk({tag, " dut3 result"}, int'(res3), 0, 0);
    chk({tag, " dut3 fpu_req"}, int'(req3), 0, 0);
    chk({tag, " dut3 fpu_op/a/b"}, int'(op3) + int'(a3) + int'(b3), 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000ns, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    start1 = 1'b0; start3 = 1'b0;
    x1 = '0; x3 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chkIdleOuts("reset");
    chk("reset dut1 fpu_op/a/b", int'(op1) + int'(a1) + int'(b1), 0, 0);

    // start held for 3 cycles also exercises start-while-busy and start-in-DONE being ignored
    issue(0, 16'h4400, 16'h37FC, 16'h3802, 2'b00, 14, 4, 3, "x=4.0", 1'b1);
    issue(0, 16'h3400, 16'h3FFC, 16'h4002, 2'b00, 14, 4, 1, "x=0.25", 1'b1);
    issue(0, 16'h3C00, 16'h3C00, 16'h3C00, 2'b00, 2, 0, 1, "x=1.0", 1'b1);
    issue(0, 16'h0000, 16'h7C00, 16'h7C00, 2'b10, 2, 0, 3, "x=+0", 1'b1);
    issue(0, 16'h8000, 16'h7C00, 16'h7C00, 2'b10, 2, 0, 1, "x=-0", 1'b1);
    issue(0, 16'hC000, 16'h7E00, 16'h7E00, 2'b11, 2, 0, 1, "x=-2", 1'b1);
    issue(0, 16'h7C01, 16'h7E00, 16'h7E00, 2'b11, 2, 0, 1, "x=NaN", 1'b1);
    issue(0, 16'h7C00, 16'h0000, 16'h0000, 2'b00, 2, 0, 1, "x=+Inf", 1'b1);
    issue(0, 16'h0001, 16'h0000, 16'h0000, 2'b01, 2, 0, 1, "x=subnormal", 1'b1);

    issue(1, 16'h4900, 16'h350F, 16'h3511, 2'b00, -1, 12, 1, "x=10 iters3", 1'b1);

    // Reset while dut3 is waiting on its SUB acknowledge
    issue(1, 16'h4900, 16'h0000, 16'h0000, 2'b00, -1, 0, 1, "aborted", 1'b0);
    n = 0;
    while (!(req3 && op3 == 2'd1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL sub wait: got no SUB request in 300 cycles, want one");
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset dut3 busy", int'(busy3), 0, 0);
    chk("midreset dut3 fpu_req", int'(req3), 0, 0);
    chk("midreset dut3 result", int'(res3), 0, 0);
    chk("midreset dut3 done", int'(done3), 0, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("post-reset dut3 done quiet", int'(done3) + int'(busy3), 0, 0);
    issue(1, 16'h4900, 16'h350F, 16'h3511, 2'b00, -1, 12, 1, "x=10 after reset", 1'b1);

    // FPU flags underflow on its second acknowledge: sequence aborts after the gap
    ackSeen = 0;
    errArm = 1'b1;
    issue(0, 16'h4400, 16'h0000, 16'h0000, 2'b01, 8, 2, 1, "fpu abort", 1'b1);

    repeat (20) @(negedge clk);
    chk("dut1 queue drained", q0.size(), 0, 0);
    chk("dut3 queue drained", q1.size(), 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
